// File: rtl/filter_sched_pkg.sv
// filter_sched_pkg: shared types and defaults for the multi-channel filter scheduler
package filter_sched_pkg;
  localparam int NCH_DEF = 4;
  localparam int W = 4;
  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_e;
  typedef struct packed {
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic [W-1:0] x3;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
  } hist_t;
endpackage

// File: rtl/filter_channel_scheduler_if.sv
// filter_channel_scheduler_if: per-channel sample inputs and shared result output
interface filter_channel_scheduler_if import filter_sched_pkg::*; #(parameter int NCH = NCH_DEF);
  localparam int CW = $clog2(NCH);
  logic [NCH-1:0]   in_valid;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_ready;
  logic [NCH-1:0]   clr;
  logic             out_valid;
  logic [CW-1:0]    out_chan;
  logic [W-1:0]     out_data;
  logic             busy;
  modport master (output in_valid, in_data, clr, input in_ready, out_valid, out_chan, out_data, busy);
  modport slave (input in_valid, in_data, clr, output in_ready, out_valid, out_chan, out_data, busy);
endinterface

// File: rtl/filter_eval.sv
// filter_eval: y = x - x1 + x2 + x3 + y1/2 + y2/4, all modulo 2^W
module filter_eval import filter_sched_pkg::*; (
  input  logic [W-1:0] x_i,
  input  hist_t        hist_i,
  output logic [W-1:0] y_o
);
  assign y_o = x_i - hist_i.x1 + hist_i.x2 + hist_i.x3 + (hist_i.y1 >> 1) + (hist_i.y2 >> 2);
endmodule

// File: rtl/filter_channel_scheduler.sv
// filter_channel_scheduler: round-robin time-multiplexing of one filter across NCH channel histories
module filter_channel_scheduler import filter_sched_pkg::*; #(parameter int NCH = NCH_DEF) (
  input logic clk,
  input logic reset,
  filter_channel_scheduler_if.slave bus
);
  localparam int CW = $clog2(NCH);
  state_e        state_q, state_d;
  logic [CW-1:0] rr_q, chan_q, out_chan_q, grant;
  logic [W-1:0]  x_q, y_q, y;
  logic          found;
  hist_t         hist_q [NCH];
  // walk offsets downward so the lowest offset from rr_q wins
  always_comb begin
    grant = rr_q;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.in_valid[(int'(rr_q) + i) % NCH]) begin
        grant = CW'((int'(rr_q) + i) % NCH);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE) ? (found ? CALC : IDLE) : (state_q == CALC) ? EMIT : IDLE;
  end
  filter_eval u_eval (.x_i(x_q), .hist_i(hist_q[chan_q]), .y_o(y));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      chan_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      out_chan_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) begin
        x_q    <= bus.in_data[W*int'(grant) +: W];
        chan_q <= grant;
      end
      if (state_q == CALC) begin
        y_q        <= y;
        out_chan_q <= chan_q;
      end
      if (state_q == EMIT) rr_q <= (chan_q == CW'(NCH - 1)) ? '0 : chan_q + 1'b1;
    end
  end
  // clr takes priority over the write-back of the sample in flight
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset || bus.clr[c]) hist_q[c] <= '0;
      else if (state_q == CALC && chan_q == CW'(c))
        hist_q[c] <= '{x1: x_q, x2: hist_q[c].x1, x3: hist_q[c].x2, y1: y, y2: hist_q[c].y1};
    end
  end
  assign bus.in_ready  = (state_q == IDLE && found) ? ({{(NCH-1){1'b0}}, 1'b1} << grant) : '0;
  assign bus.out_valid = state_q == EMIT;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_data  = y_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_filter_channel_scheduler.sv
// tb_filter_channel_scheduler: vector table plus hand sequences, scoreboarded against out_valid pulses
module tb_filter_channel_scheduler;
  import filter_sched_pkg::*;
  localparam int N = 4;
  typedef struct { int ch; logic [3:0] y; } exp_t;
  typedef struct { int ch; logic [3:0] x; logic [3:0] y; } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  int acc_q[$];
  exp_t e;
  vec_t vecs[11];
  filter_channel_scheduler_if #(.NCH(N)) bus();
  filter_channel_scheduler #(.NCH(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (reset) acc_q.delete();
    else begin
      if ((bus.in_valid & bus.in_ready) != 0) acc_q.push_back(cyc);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected out_valid: chan %0d data %0d, none expected", bus.out_chan, bus.out_data);
        end else begin
          e = sb.pop_front();
          check("out_chan", 32'(bus.out_chan), 32'(e.ch));
          check("out_data", 32'(bus.out_data), 32'(e.y));
          check("latency", acc_q.size() > 0 ? 32'(cyc - acc_q.pop_front()) : 32'hFFFF_FFFF, 32'd2);
        end
      end
    end
  end
  // called at posedge+1; returns at posedge+1 right after the accepting edge (DUT in CALC)
  task automatic send(int ch, logic [3:0] x, logic [3:0] y, bit expect_out);
    int n = 0;
    bus.in_valid[ch] = 1'b1;
    bus.in_data[ch*4 +: 4] = x;
    if (expect_out) sb.push_back('{ch, y});
    #1;
    while (!bus.in_ready[ch] && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n == 20) check("grant timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 bus.in_valid[ch] = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1 check("drain", 32'(sb.size()), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [N-1:0] g;
    int n;
    vecs = '{'{0, 4'd4, 4'd4}, '{0, 4'd4, 4'd2}, '{0, 4'd4, 4'd6},
             '{1, 4'd4, 4'd4}, '{2, 4'd4, 4'd4}, '{1, 4'd4, 4'd2},
             '{2, 4'd4, 4'd2}, '{1, 4'd4, 4'd6}, '{2, 4'd4, 4'd6},
             '{3, 4'd1, 4'd1}, '{3, 4'd0, 4'd15}};
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.clr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_chan", 32'(bus.out_chan), 32'd0);
    check("reset out_data", 32'(bus.out_data), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    foreach (vecs[i]) begin
      send(vecs[i].ch, vecs[i].x, vecs[i].y, 1'b1);
      drain();
    end
    // ch0 history is x=4,4,4 y1=6 y2=2, so y=11; clr during CALC wipes history
    send(0, 4'd4, 4'd11, 1'b1);
    check("busy in CALC", 32'(bus.busy), 32'd1);
    bus.clr[0] = 1'b1;
    @(posedge clk);
    #1 bus.clr[0] = 1'b0;
    drain();
    send(0, 4'd4, 4'd4, 1'b1);
    drain();
    send(1, 4'd6, 4'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("post-reset busy", 32'(bus.busy), 32'd0);
    check("post-reset in_ready", 32'(bus.in_ready), 32'd0);
    check("post-reset out_valid", 32'(bus.out_valid), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    bus.in_data = {4'd9, 4'd3, 4'd7, 4'd5};
    bus.in_valid = 4'hF;
    sb.push_back('{0, 4'd5});
    sb.push_back('{1, 4'd7});
    sb.push_back('{2, 4'd3});
    sb.push_back('{3, 4'd9});
    n = 0;
    while (bus.in_valid != 0 && n < 40) begin
      @(negedge clk);
      g = bus.in_ready & bus.in_valid;
      @(posedge clk);
      #1 bus.in_valid = bus.in_valid & ~g;
      n++;
    end
    if (n == 40) check("all-valid grant timeout", 32'(bus.in_valid), 32'd0);
    drain();
    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
